hvac_sequencer: RTL and testbench
=================================

# hvac_sequencer

Sequences the heater, cooler and fan actuators of the thermostat once the start driver asserts RUN. It compares the measured temperature against the setpoint with hysteresis and drives a pre-ventilation, active, post-ventilation and lockout cycle, with minimum on and off times to protect the actuators. It sits between the start driver's RUN output and the actuator output pins.

## Interface
- W, 8: width of TEMP and SETPOINT, unsigned.
- HYST, 2: hysteresis band in LSBs, ≥ 0.
- PRE_CYC, 4: fan pre-ventilation length in cycles, ≥ 1.
- POST_CYC, 8: fan post-ventilation length in cycles, ≥ 1.
- MIN_ON, 16: minimum cycles in HEAT or COOL before a temperature-driven exit, ≥ 1.
- MIN_OFF, 16: lockout length in cycles after every active cycle, ≥ 1.
- CW, 16: internal counter width; must hold max(PRE_CYC, POST_CYC, MIN_ON, MIN_OFF).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- RUN  in  1  enable from the start driver, synchronous to clk.
- TEMP  in  W  measured temperature.
- SETPOINT  in  W  target temperature.
- HEAT  out  1  heater enable, registered.
- COOL  out  1  cooler enable, registered.
- FAN  out  1  fan enable, registered.
- STATE  out  3  current state code, registered.
- BUSY  out  1  high in every state except IDLE.

## Operation
- States and codes: IDLE=0, PRE=1, HEAT=2, COOL=3, POST=4, LOCK=5. Codes 6 and 7 are illegal and return to IDLE on the next edge.
- Demand is computed in W+2-bit signed arithmetic, so there is no wrap at 0 or 2^W−1.
  - heat_req = TEMP < SETPOINT − HYST.
  - cool_req = TEMP > SETPOINT + HYST.
  - The two requests are mutually exclusive by construction.
- A mode register stores heat or cool. It is latched on the IDLE→PRE transition and is held until the next IDLE→PRE transition.
- IDLE: all outputs 0.
  - RUN=1 and heat_req: go to PRE with mode=heat.
  - RUN=1 and cool_req: go to PRE with mode=cool.
  - Otherwise stay in IDLE.
- PRE: FAN=1. After exactly PRE_CYC cycles, go to HEAT or COOL according to mode. RUN=0 in PRE aborts directly to IDLE; no lockout, since nothing was energized.
- HEAT: FAN=1, HEAT=1. Go to POST when either:
  - RUN=0, immediately and regardless of MIN_ON; or
  - on_cnt ≥ MIN_ON−1 and TEMP ≥ SETPOINT.
- COOL: FAN=1, COOL=1. Exit rules mirror HEAT, with the temperature condition TEMP ≤ SETPOINT.
- POST: FAN=1. After exactly POST_CYC cycles, go to LOCK. RUN has no effect in POST.
- LOCK: all actuators 0. After exactly MIN_OFF cycles, go to IDLE. RUN has no effect in LOCK.
- Counters:
  - One shared counter is cleared on every state change and increments each cycle otherwise.
  - A timed state exits on the edge where counter == N−1, so the state lasts exactly N cycles.
  - In HEAT/COOL the counter saturates at MIN_ON−1.
- HEAT and COOL are never both 1. HEAT or COOL = 1 implies FAN = 1.

## Timing
- Reset (asynchronous): state IDLE; HEAT=COOL=FAN=0; STATE=0; BUSY=0; counter=0; mode=heat.
  - Reset asserted mid-cycle clears all actuators immediately, without waiting for a clock edge.
  - After reset release, the block evaluates demand on the first rising edge.
- Outputs are decoded from the next state and registered, so they change on the same edge as STATE.
- Latency from RUN=1 with a demand present to FAN=1: 1 edge.
- Latency to HEAT/COOL = 1: 1 + PRE_CYC edges.
- Active exit to FAN=0: POST_CYC edges after entering POST.
- Minimum time from the end of POST to the next FAN=1: MIN_OFF + 1 edges.
- TEMP and SETPOINT are sampled every edge. No internal synchronizer is provided; inputs are assumed stable with respect to clk.

## Test plan
Parameters for all scenarios: HYST=2, PRE_CYC=4, POST_CYC=3, MIN_ON=6, MIN_OFF=5, SETPOINT=20.
- Reset/idle: hold rst=1 with RUN=1, TEMP=10 → all outputs 0 and STATE=0. Release rst → FAN=1 at the first edge; HEAT=1 after 4 more edges.
- Hysteresis band: RUN=1 with TEMP at 18, 20 and 22 → stays in IDLE for each value. TEMP=17 → heat cycle starts. TEMP=23 → cool cycle starts.
- Minimum on time: heat cycle with TEMP stepped to 25 on the 2nd HEAT cycle → HEAT stays high for exactly 6 cycles; then FAN alone for 3 cycles; then all 0 for 5 cycles; then IDLE.
- RUN drop: RUN=0 on the 2nd HEAT cycle → HEAT=0 on the next edge, followed by 3 POST cycles and 5 LOCK cycles. RUN=0 during PRE instead → IDLE on the next edge, FAN=0, no LOCK.
- Lockout: cool demand held continuously (TEMP=30) with a reached-setpoint pulse → after LOCK, FAN rises exactly 1 edge after IDLE is reached. COOL and HEAT are never both 1 at any point.
- Boundaries: SETPOINT=0, TEMP=0 → no heat request (no underflow). SETPOINT=255, TEMP=255 → no cool request. Asynchronous rst pulse during HEAT → outputs drop to 0 before the next clock edge.

Source files
------------

// File: rtl/hvac_sequencer_if.sv
// hvac_sequencer_if: RUN/temperature inputs and actuator/status outputs of the HVAC sequencer
interface hvac_sequencer_if #(parameter int W = 8);
   logic         RUN;
   logic [W-1:0] TEMP;
   logic [W-1:0] SETPOINT;
   logic         HEAT;
   logic         COOL;
   logic         FAN;
   logic [2:0]   STATE;
   logic         BUSY;
   modport master (output RUN, TEMP, SETPOINT, input HEAT, COOL, FAN, STATE, BUSY);
   modport slave  (input RUN, TEMP, SETPOINT, output HEAT, COOL, FAN, STATE, BUSY);
endinterface

// File: rtl/hvac_sequencer.sv
// hvac_sequencer: heater/cooler/fan sequencing with hysteresis, pre/post ventilation,
// minimum on time and lockout; outputs are registered from the next state
module hvac_sequencer #(
   parameter int W        = 8,
   parameter int HYST     = 2,
   parameter int PRE_CYC  = 4,
   parameter int POST_CYC = 8,
   parameter int MIN_ON   = 16,
   parameter int MIN_OFF  = 16,
   parameter int CW       = 16
) (
   input logic            clk,
   input logic            rst,
   hvac_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_PRE = 3'd1, S_HEAT = 3'd2, S_COOL = 3'd3, S_POST = 3'd4, S_LOCK = 3'd5
   } state_e;
   localparam logic signed [W+1:0] HY = (W+2)'(HYST);
   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                cool_mode_q, cool_mode_d;
   logic                heat_q, cool_q, fan_q, busy_q;
   logic                heat_d, cool_d, fan_d, busy_d;
   logic signed [W+1:0] temp_s, sp_s;
   logic                heat_req, cool_req, min_on_met;
   // two guard bits keep SETPOINT +/- HYST from wrapping at either end of the range
   assign temp_s     = $signed({2'b00, bus.TEMP});
   assign sp_s       = $signed({2'b00, bus.SETPOINT});
   assign heat_req   = temp_s < sp_s - HY;
   assign cool_req   = temp_s > sp_s + HY;
   assign min_on_met = cnt_q >= CW'(MIN_ON - 1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         cool_mode_q <= 1'b0;
         heat_q      <= 1'b0;
         cool_q      <= 1'b0;
         fan_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cool_mode_q <= cool_mode_d;
         heat_q      <= heat_d;
         cool_q      <= cool_d;
         fan_q       <= fan_d;
         busy_q      <= busy_d;
      end
   end
   always_comb begin
      state_d     = S_IDLE;
      cool_mode_d = cool_mode_q;
      case (state_q)
         S_IDLE: if (bus.RUN && (heat_req || cool_req)) begin
            state_d     = S_PRE;
            cool_mode_d = cool_req;
         end
         S_PRE:  state_d = !bus.RUN ? S_IDLE :
                           cnt_q == CW'(PRE_CYC - 1) ? (cool_mode_q ? S_COOL : S_HEAT) : S_PRE;
         S_HEAT: state_d = (!bus.RUN || (min_on_met && bus.TEMP >= bus.SETPOINT)) ? S_POST : S_HEAT;
         S_COOL: state_d = (!bus.RUN || (min_on_met && bus.TEMP <= bus.SETPOINT)) ? S_POST : S_COOL;
         S_POST: state_d = cnt_q == CW'(POST_CYC - 1) ? S_LOCK : S_POST;
         S_LOCK: state_d = cnt_q == CW'(MIN_OFF - 1) ? S_IDLE : S_LOCK;
         default: state_d = S_IDLE;
      endcase
      cnt_d = state_d != state_q ? '0 :
              (state_q inside {S_HEAT, S_COOL}) && min_on_met ? cnt_q : cnt_q + CW'(1);
   end
   always_comb begin
      heat_d = state_d == S_HEAT;
      cool_d = state_d == S_COOL;
      fan_d  = state_d inside {S_PRE, S_HEAT, S_COOL, S_POST};
      busy_d = state_d != S_IDLE;
   end
   assign bus.HEAT  = heat_q;
   assign bus.COOL  = cool_q;
   assign bus.FAN   = fan_q;
   assign bus.STATE = state_q;
   assign bus.BUSY  = busy_q;
endmodule

// File: tb/tb_hvac_sequencer.sv
// tb_hvac_sequencer: directed and random stimulus against a countdown-timer reference model,
// expectations queued per edge and compared by an independent negedge monitor
module tb_hvac_sequencer;
   localparam int HYST = 2, PRE_CYC = 4, POST_CYC = 3, MIN_ON = 6, MIN_OFF = 5;
   typedef struct packed {
      logic       heat;
      logic       cool;
      logic       fan;
      logic [2:0] state;
      logic       busy;
   } obs_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   hvac_sequencer_if #(.W(8)) bus ();
   hvac_sequencer #(
      .W(8), .HYST(HYST), .PRE_CYC(PRE_CYC), .POST_CYC(POST_CYC),
      .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .CW(16)
   ) dut (.clk(clk), .rst(rst), .bus(bus));
   obs_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   ph = 0;
   int   left = 0;
   int   on_cyc = 0;
   bit   m_cool = 1'b0;
   function automatic obs_t observed();
      return {bus.HEAT, bus.COOL, bus.FAN, bus.STATE, bus.BUSY};
   endfunction
   function automatic obs_t expected();
      return {ph == 2, ph == 3, ph >= 1 && ph <= 4, 3'(ph), ph != 0};
   endfunction
   task automatic check(input string name, input obs_t got, input obs_t want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s @%0t: got heat=%0b cool=%0b fan=%0b state=%0d busy=%0b, want heat=%0b cool=%0b fan=%0b state=%0d busy=%0b",
                  name, $time, got.heat, got.cool, got.fan, got.state, got.busy,
                  want.heat, want.cool, want.fan, want.state, want.busy);
      end
   endtask
   task automatic check_bit(input string name, input logic got, input logic want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s @%0t: got %0b, want %0b", name, $time, got, want);
      end
   endtask
   // reference: phase plus cycles remaining in timed phases, cycles spent in active phase
   task automatic model(input bit r, input int t, input int s);
      case (ph)
         0: if (r && t < s - HYST) begin ph = 1; left = PRE_CYC; m_cool = 1'b0; end
            else if (r && t > s + HYST) begin ph = 1; left = PRE_CYC; m_cool = 1'b1; end
         1: if (!r) ph = 0;
            else if (left == 1) begin ph = m_cool ? 3 : 2; on_cyc = 1; end
            else left--;
         2, 3: if (!r || (on_cyc >= MIN_ON && (ph == 2 ? t >= s : t <= s))) begin ph = 4; left = POST_CYC; end
               else on_cyc++;
         4: if (left == 1) begin ph = 5; left = MIN_OFF; end else left--;
         5: if (left == 1) ph = 0; else left--;
         default: ph = 0;
      endcase
   endtask
   task automatic drive(input bit r, input int t, input int s);
      @(negedge clk);
      #1;
      rst          = 1'b0;
      bus.RUN      = r;
      bus.TEMP     = 8'(t);
      bus.SETPOINT = 8'(s);
      model(r, t, s);
      exp_q.push_back(expected());
   endtask
   task automatic drive_n(input int n, input bit r, input int t, input int s);
      for (int i = 0; i < n; i++) drive(r, t, s);
   endtask
   always @(negedge clk) begin
      obs_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("cycle", observed(), e);
         check_bit("heat_cool_excl", bus.HEAT & bus.COOL, 1'b0);
         check_bit("act_implies_fan", (bus.HEAT | bus.COOL) & ~bus.FAN, 1'b0);
      end
   end
   initial begin
      int sp, tt;
      bus.RUN = 1'b1; bus.TEMP = 8'd10; bus.SETPOINT = 8'd20;
      repeat (3) @(negedge clk);
      #1 check("reset_hold", observed(), '0);
      // heat cycle straight out of reset, exit once setpoint is exceeded
      drive_n(10, 1'b1, 10, 20);
      drive_n(15, 1'b1, 25, 20);
      // hysteresis band, then PRE abort, then cool with RUN drop
      drive_n(3, 1'b1, 18, 20);
      drive_n(3, 1'b1, 20, 20);
      drive_n(3, 1'b1, 22, 20);
      drive_n(2, 1'b1, 17, 20);
      drive_n(3, 1'b0, 17, 20);
      drive_n(7, 1'b1, 23, 20);
      drive_n(12, 1'b0, 23, 20);
      // minimum on time: setpoint exceeded on the 2nd HEAT cycle
      drive_n(6, 1'b1, 10, 20);
      drive_n(20, 1'b1, 25, 20);
      // RUN drop on the 2nd HEAT cycle
      drive_n(6, 1'b1, 10, 20);
      drive_n(12, 1'b0, 10, 20);
      // continuous cool demand with one reached-setpoint pulse, then restart after lockout
      drive_n(11, 1'b1, 30, 20);
      drive(1'b1, 20, 20);
      drive_n(14, 1'b1, 30, 20);
      drive_n(20, 1'b0, 30, 20);
      // range boundaries
      drive_n(3, 1'b1, 0, 0);
      drive_n(3, 1'b1, 255, 255);
      drive_n(3, 1'b1, 0, 255);
      drive_n(20, 1'b0, 0, 255);
      // randomized demand around a wandering setpoint
      sp = 20;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) sp = $urandom_range(0, 255);
         tt = sp + int'($urandom_range(0, 14)) - 7;
         tt = tt < 0 ? 0 : tt > 255 ? 255 : tt;
         drive($urandom_range(0, 15) != 0, tt, sp);
      end
      drive_n(20, 1'b0, 20, 20);
      // asynchronous reset in the middle of a heat cycle
      drive_n(7, 1'b1, 10, 20);
      @(negedge clk);
      #2 check_bit("heat_before_rst", bus.HEAT, 1'b1);
      rst = 1'b1;
      #1 check("async_rst", observed(), '0);
      ph = 0; left = 0; on_cyc = 0; m_cool = 1'b0;
      @(posedge clk);
      #1 check("rst_over_edge", observed(), '0);
      drive_n(8, 1'b1, 10, 20);
      repeat (2) @(negedge clk);
      #1 check_bit("queue_drained", exp_q.size() == 0, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
